// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store controller with stall and MEM/WB register
//
// Purpose: takes the EX/MEM pipeline register outputs and runs the load or store
//   against a variable-latency data memory (memReq/memReady handshake). While an
//   access is outstanding it raises stall. It selects the writeback value and
//   registers it into the MEM/WB outputs.
//
// Optional feature: MEM_TIMEOUT_EN
//   Defined: a BUSY access with no memReady for TIMEOUT_CYCLES request cycles is
//     aborted and the sticky memErr flag is set.
//   Undefined: BUSY waits indefinitely and memErr is tied to 0.
//
// Ports:
//   clk, reset                   clock (rising edge), asynchronous active-low reset
//   regWrEn, memWrEn             EX/MEM register-write and memory-write enables
//   isLoad, isStore              EX/MEM instruction class; load wins if both set
//   mulSel                       writeback select: 00 aluOut, 01 read data, 10 PC, 11 zero
//   regWrAddr                    destination register
//   aluOut, PC, dataIn           address / ALU result, link PC, store data
//   memReq, memWe                memory request and write strobe
//   memAddr, memWrData           memory address and write data
//   memReady, memRdData          memory completion and read data
//   stall                        holds the upstream pipeline registers
//   wbEn, wbAddr, wbData         registered MEM/WB outputs
//   memErr                       sticky timeout error

module mem_access_unit #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regWrEn,
  input  logic                 memWrEn,
  input  logic                 isLoad,
  input  logic                 isStore,
  input  logic [1:0]           mulSel,
  input  logic [3:0]           regWrAddr,
  input  logic [BIT_WIDTH-1:0] aluOut,
  input  logic [BIT_WIDTH-1:0] PC,
  input  logic [BIT_WIDTH-1:0] dataIn,
  output logic                 memReq,
  output logic                 memWe,
  output logic [BIT_WIDTH-1:0] memAddr,
  output logic [BIT_WIDTH-1:0] memWrData,
  input  logic                 memReady,
  input  logic [BIT_WIDTH-1:0] memRdData,
  output logic                 stall,
  output logic                 wbEn,
  output logic [3:0]           wbAddr,
  output logic [BIT_WIDTH-1:0] wbData,
  output logic                 memErr
);

  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state;
  state_t               nextState;
  logic                 acc;
  logic                 reqRaw;
  logic                 abort;
  logic [BIT_WIDTH-1:0] wbMux;

  assign acc       = isLoad | (isStore & memWrEn);
  assign memWe     = isStore & memWrEn & ~isLoad;
  assign memAddr   = aluOut;
  assign memWrData = dataIn;

`ifdef MEM_TIMEOUT_EN
  localparam int             CW      = $clog2(TIMEOUT_CYCLES);
  // The IDLE cycle that launched the access is the first request cycle, so the
  // abort fires on the BUSY cycle whose incremented count would hit TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] toCnt;
`endif

  always_comb begin
    nextState = state;
    reqRaw    = 1'b0;
    abort     = 1'b0;
    if (state == IDLE) begin
      reqRaw = acc;
      if (acc && !memReady) nextState = BUSY;
    end else begin
      reqRaw = 1'b1;
      if (memReady) begin
        nextState = IDLE;
      end
`ifdef MEM_TIMEOUT_EN
      else if (toCnt == TO_LAST) begin
        abort     = 1'b1;
        nextState = IDLE;
      end
`endif
    end
  end

  // Gated by reset so nothing is requested while the unit is held in reset,
  // even though IDLE would otherwise follow acc.
  assign memReq = reqRaw & reset & ~abort;
  assign stall  = memReq & ~memReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    wbMux = '0;
    case (mulSel)
      2'b00:   wbMux = aluOut;
      2'b01:   wbMux = memRdData;
      2'b10:   wbMux = PC;
      default: wbMux = '0;
    endcase
  end

  // A stalled or aborted cycle inserts a bubble; address/data hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbEn   <= 1'b0;
      wbAddr <= '0;
      wbData <= '0;
    end else if (stall || abort) begin
      wbEn   <= 1'b0;
    end else begin
      wbEn   <= regWrEn;
      wbAddr <= regWrAddr;
      wbData <= wbMux;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 toCnt <= '0;
    else if (nextState == IDLE) toCnt <= '0;
    else if (state == BUSY)     toCnt <= toCnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     memErr <= 1'b0;
    else if (abort) memErr <= 1'b1;
  end
`else
  assign memErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit

module tb_mem_access_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         regWrEn, memWrEn, isLoad, isStore;
  logic [1:0]   mulSel;
  logic [3:0]   regWrAddr;
  logic [W-1:0] aluOut, PC, dataIn;
  logic         memReq, memWe;
  logic [W-1:0] memAddr, memWrData;
  logic         memReady;
  logic [W-1:0] memRdData;
  logic         stall, wbEn;
  logic [3:0]   wbAddr;
  logic [W-1:0] wbData;
  logic         memErr;

  int checks   = 0;
  int failures = 0;
  int stallCnt = 0;

  // reference state: last committed writeback and sticky error
  logic [3:0]   expWbAddr = '0;
  logic [W-1:0] expWbData = '0;
  logic         expErr    = 1'b0;

  mem_access_unit #(.BIT_WIDTH(W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .regWrEn(regWrEn), .memWrEn(memWrEn), .isLoad(isLoad), .isStore(isStore),
    .mulSel(mulSel), .regWrAddr(regWrAddr),
    .aluOut(aluOut), .PC(PC), .dataIn(dataIn),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWrData(memWrData),
    .memReady(memReady), .memRdData(memRdData),
    .stall(stall), .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData), .memErr(memErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One instruction held on the EX/MEM inputs until the memory completes it.
  // lat = number of wait cycles before memReady (ignored for non-memory ops).
  // Called, and returns, 1 time unit after a rising edge.
  task automatic doInstr(input logic rwe, input logic mwe, input logic ld, input logic st,
                         input logic [1:0] sel, input logic [3:0] ra,
                         input logic [W-1:0] alu, input logic [W-1:0] pcv,
                         input logic [W-1:0] din, input logic [W-1:0] rd, input int lat);
    logic         acc;
    int           nl;
    logic [W-1:0] expData;
    acc = ld | (st & mwe);
    nl  = acc ? lat : 0;
    regWrEn = rwe; memWrEn = mwe; isLoad = ld; isStore = st;
    mulSel = sel; regWrAddr = ra; aluOut = alu; PC = pcv; dataIn = din;
    for (int c = 0; c <= nl; c++) begin
      memReady  = acc ? (c == nl) : 1'($urandom);
      memRdData = (c == nl) ? rd : $urandom;
      @(negedge clk);
      check("memReq", memReq, acc);
      check("stall", stall, acc && (c < nl));
      if (acc) begin
        check("memWe", memWe, st & mwe & ~ld);
        check("memAddr", memAddr, alu);
        check("memWrData", memWrData, din);
      end
      if (stall) stallCnt++;
      @(posedge clk); #1;
      if (c < nl) begin
        check("wbEn_bubble", wbEn, 0);
        check("wbAddr_hold", wbAddr, expWbAddr);
        check("wbData_hold", wbData, expWbData);
      end
    end
    case (sel)
      2'b00:   expData = alu;
      2'b01:   expData = rd;
      2'b10:   expData = pcv;
      default: expData = '0;
    endcase
    check("wbEn", wbEn, rwe);
    check("wbAddr", wbAddr, ra);
    check("wbData", wbData, expData);
    check("memErr", memErr, expErr);
    expWbAddr = ra;
    expWbData = expData;
  endtask

  task automatic idleInputs();
    regWrEn = 0; memWrEn = 0; isLoad = 0; isStore = 0; mulSel = 0; regWrAddr = 0;
    aluOut = 0; PC = 0; dataIn = 0; memReady = 0; memRdData = 0;
  endtask

  initial begin
    int s0;
    idleInputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_memReq", memReq, 0);
    check("rst_stall", stall, 0);
    check("rst_wbEn", wbEn, 0);
    check("rst_wbAddr", wbAddr, 0);
    check("rst_wbData", wbData, 0);
    check("rst_memErr", memErr, 0);
    reset = 1'b1;

    // ALU op passes through in one cycle
    doInstr(1, 0, 0, 0, 2'b00, 4'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 0);
    // zero-wait load
    s0 = stallCnt;
    doInstr(1, 0, 1, 0, 2'b01, 4'd7, 32'h40, 32'h0, 32'h0, 32'hCAFE, 0);
    check("zero_wait_stalls", stallCnt - s0, 0);
    // store with 3 wait cycles
    s0 = stallCnt;
    doInstr(0, 1, 0, 1, 2'b00, 4'd2, 32'h80, 32'h0, 32'hBEEF, 32'h0, 3);
    check("store_stalls", stallCnt - s0, 3);
    // back-to-back loads with one wait each
    s0 = stallCnt;
    doInstr(1, 0, 1, 0, 2'b01, 4'd3, 32'h100, 32'h0, 32'h0, 32'h1111_2222, 1);
    doInstr(1, 0, 1, 0, 2'b01, 4'd4, 32'h104, 32'h0, 32'h0, 32'h3333_4444, 1);
    check("b2b_stalls", stallCnt - s0, 2);
    // load+store both set behaves as a load; link PC writeback; zero select
    doInstr(1, 1, 1, 1, 2'b01, 4'd9, 32'h200, 32'h0, 32'h55, 32'hABCD, 2);
    doInstr(1, 0, 0, 0, 2'b10, 4'd15, 32'h0, 32'h400, 32'h0, 32'h0, 0);
    doInstr(1, 0, 0, 0, 2'b11, 4'd1, 32'hFFFF, 32'h8, 32'h0, 32'h0, 0);
    // store without memWrEn is not an access
    doInstr(1, 0, 0, 1, 2'b00, 4'd6, 32'h77, 32'h0, 32'h99, 32'h0, 2);

    // reset pulsed while BUSY
    isLoad = 1; memWrEn = 0; isStore = 0; regWrEn = 1; mulSel = 2'b01;
    regWrAddr = 4'd8; aluOut = 32'h300; memReady = 0;
    @(posedge clk); #2;
    check("busy_memReq", memReq, 1);
    reset = 1'b0; #1;
    check("rstmid_memReq", memReq, 0);
    check("rstmid_stall", stall, 0);
    check("rstmid_wbEn", wbEn, 0);
    check("rstmid_wbData", wbData, 0);
    expWbAddr = '0; expWbData = '0;
    @(negedge clk);
    isLoad = 0; reset = 1'b1;
    #1;
    check("post_rst_idle_memReq", memReq, 0);
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    // memory never answers: abort on the 4th request cycle
    regWrEn = 1; memWrEn = 0; isLoad = 1; isStore = 0; mulSel = 2'b01;
    regWrAddr = 4'd12; aluOut = 32'h500; memReady = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("to_memReq", memReq, c < 3);
      check("to_stall", stall, c < 3);
      @(posedge clk); #1;
      check("to_wbEn", wbEn, 0);
    end
    expErr = 1'b1;
    check("to_memErr", memErr, 1);
    doInstr(1, 0, 0, 0, 2'b00, 4'd13, 32'h600, 32'h0, 32'h0, 32'h0, 0);
`endif

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [3:0] k;
      k = 4'($urandom);
      doInstr(1'($urandom), k[0], k[1] & k[2], k[3], 2'($urandom), 4'($urandom),
              $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    check("final_memErr", memErr, expErr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
